// File: rtl/jsilicon_pkg.sv
// ============================================================================
//  Module      : jsilicon_pkg
//  Description : Shared opcode encodings, control-FSM state type and a
//                constant clog2 helper for the Jsilicon accumulator CPU.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package jsilicon_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // Constant-evaluable ceil(log2(value)); value 1 yields 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jsilicon_alu.sv
// ============================================================================
//  Module      : jsilicon_alu
//  Description : Combinational ALU for the immediate/shift opcodes.
//                Ports: i_a (rd value), i_b (zero-extended immediate),
//                i_op (opcode), o_result, o_carry, o_zero.
//                Opcodes without an ALU meaning pass i_b through.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module jsilicon_alu
    import jsilicon_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    // One extra bit so the carry-out / borrow falls out of the MSB.
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_b;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADDI: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUBI: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OP_ANDI: o_result = i_a & i_b;
            OP_ORI:  o_result = i_a | i_b;
            OP_XORI: o_result = i_a ^ i_b;
            OP_SHL: begin
                o_result = {i_a[DATA_W-2:0], 1'b0};
                o_carry  = i_a[DATA_W-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[DATA_W-1:1]};
                o_carry  = i_a[0];
            end
            default: ;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/jsilicon_cpu.sv
// ============================================================================
//  Module      : jsilicon_cpu
//  Description : Handshaked accumulator-style CPU: PC, loadable IMEM,
//                decoder, register file, ALU and control FSM.
//                Ports: clk/rst; i_prog_we/i_prog_addr/i_prog_data (IMEM
//                load, IDLE/HALT only); i_run; i_step_valid/i_step_instr
//                (single-step, IDLE only); o_out_valid/o_out_data/
//                i_out_ready (output stream); o_busy, o_halted, o_retire,
//                o_pc, o_zero, o_carry (status).
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module jsilicon_cpu
    import jsilicon_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREGS      = 4,
    parameter  int IMM_W      = 4,
    parameter  int IMEM_DEPTH = 16,
    localparam int RSEL_W     = clog2(NREGS),
    localparam int PC_W       = clog2(IMEM_DEPTH),
    localparam int INSTR_W    = 4 + RSEL_W + IMM_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_prog_we,
    input  logic [PC_W-1:0]    i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
    input  logic               i_run,
    input  logic               i_step_valid,
    input  logic [INSTR_W-1:0] i_step_instr,
    output logic               o_out_valid,
    output logic [DATA_W-1:0]  o_out_data,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_retire,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_zero,
    output logic               o_carry
);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic                r_step;       // current instruction came from step port
    logic                r_zero;
    logic                r_carry;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_retire;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic [INSTR_W-1:0]  r_imem [IMEM_DEPTH];

    logic [3:0]          w_op;
    logic [RSEL_W-1:0]   w_rd;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_carry;
    logic                w_alu_zero;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_wen;
    logic                w_flag_op;
    logic [PC_W-1:0]     w_pc_next;

    assign w_op      = r_ir[INSTR_W-1 -: 4];
    assign w_rd      = r_ir[IMM_W +: RSEL_W];
    assign w_imm     = r_ir[IMM_W-1:0];
    assign w_imm_ext = DATA_W'(w_imm);
    assign w_rd_val  = r_regs[w_rd];
    assign w_flag_op = (w_op >= OP_ADDI) && (w_op <= OP_SHR);
    assign w_wen     = w_flag_op || (w_op == OP_LDI) || (w_op == OP_MOV);

    jsilicon_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (w_rd_val),
        .i_b      (w_imm_ext),
        .i_op     (w_op),
        .o_result (w_alu_res),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_comb begin
        w_wdata = w_alu_res;
        if (w_op == OP_LDI) begin
            w_wdata = w_imm_ext;
        end else if (w_op == OP_MOV) begin
            w_wdata = r_regs[0];
        end
    end

    // Sequential pc wraps naturally at IMEM_DEPTH (power of two).
    always_comb begin
        w_pc_next = r_pc + PC_W'(1);
        if ((w_op == OP_JMP) || ((w_op == OP_JNZ) && (w_rd_val != '0))) begin
            w_pc_next = w_imm[PC_W-1:0];
        end
    end

    // Instruction memory: no reset so a program survives rst. Writes are
    // accepted only while the core is parked, so a write in the same cycle
    // as run is visible to the very first fetch.
    always_ff @(posedge clk) begin
        if (i_prog_we && ((r_state == ST_IDLE) || (r_state == ST_HALT))) begin
            r_imem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_step      <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_retire    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // run has priority; a simultaneous step is dropped
                    if (i_run) begin
                        r_pc    <= '0;
                        r_step  <= 1'b0;
                        r_state <= ST_FETCH;
                    end else if (i_step_valid) begin
                        r_ir    <= i_step_instr;
                        r_step  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= r_imem[r_pc];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Step mode never moves pc, which also neuters JMP/JNZ.
                    if (!r_step) begin
                        r_pc <= w_pc_next;
                    end
                    if (w_flag_op) begin
                        r_zero  <= w_alu_zero;
                        r_carry <= w_alu_carry;
                    end
                    if (w_wen) begin
                        r_regs[w_rd] <= w_wdata;
                    end
                    if (w_op == OP_OUT) begin
                        // retire deferred until the consumer takes the word
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rd_val;
                        r_state     <= ST_OUT_WAIT;
                    end else if ((w_op == OP_HALT) && !r_step) begin
                        r_retire <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_retire <= 1'b1;
                        r_state  <= r_step ? ST_IDLE : ST_FETCH;
                    end
                end
                ST_OUT_WAIT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_retire    <= 1'b1;
                        r_state     <= r_step ? ST_IDLE : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (i_run) begin
                        r_pc    <= '0;
                        r_step  <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                         (r_state == ST_OUT_WAIT);
    assign o_halted    = (r_state == ST_HALT);
    assign o_retire    = r_retire;
    assign o_pc        = r_pc;
    assign o_zero      = r_zero;
    assign o_carry     = r_carry;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

`default_nettype wire
